// File: rtl/arbitro_quadro_matriz_pkg.sv
// rtl/arbitro_quadro_matriz_pkg.sv - shared constants and types for the double-buffered matrix arbiter
package arbitro_quadro_matriz_pkg;

  localparam int CICLOS_QUADRO_PADRAO = 2048;
  localparam int LARGURA_LINHA        = 8;
  localparam int NUM_LINHAS           = 8;
  localparam int LARG_IDX_LINHA       = $clog2(NUM_LINHAS);

  typedef logic [LARGURA_LINHA-1:0]  linha_t;
  typedef logic [LARG_IDX_LINHA-1:0] idx_linha_t;

  typedef enum logic [1:0] {
    OCIOSO        = 2'd0,
    LIMPEZA       = 2'd1,
    AGUARDA_TROCA = 2'd2
  } estado_t;

  // Identity of the requester that won the most recent grant.
  typedef enum logic {
    JOGO = 1'b0,
    SOB  = 1'b1
  } requisitante_t;

endpackage

// File: rtl/arbitro_rr2.sv
// rtl/arbitro_rr2.sv - two-way round-robin grant with last-winner pointer
module arbitro_rr2
  import arbitro_quadro_matriz_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       habilita,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  requisitante_t ultimo_q, ultimo_d;

  always_comb begin
    grant = 2'b00;
    if (habilita) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (ultimo_q == SOB) ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  always_comb begin
    ultimo_d = ultimo_q;
    if (grant[0]) begin
      ultimo_d = JOGO;
    end else if (grant[1]) begin
      ultimo_d = SOB;
    end
  end

  // Pointer starts on overlay so the game side wins the first tie.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ultimo_q <= SOB;
    end else begin
      ultimo_q <= ultimo_d;
    end
  end

endmodule

// File: rtl/arbitro_quadro_matriz.sv
// rtl/arbitro_quadro_matriz.sv - double-buffered 8x8 frame store with two writers and frame-synchronous swap
module arbitro_quadro_matriz
  import arbitro_quadro_matriz_pkg::*;
#(
  parameter int CICLOS_QUADRO = CICLOS_QUADRO_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_jogo,
  input  logic [2:0] linha_jogo,
  input  logic [7:0] dado_jogo,
  output logic       ack_jogo,
  input  logic       req_sob,
  input  logic [2:0] linha_sob,
  input  logic [7:0] dado_sob,
  output logic       ack_sob,
  input  logic       limpar,
  input  logic       troca_req,
  output logic       troca_pendente,
  output logic       troca_feita,
  output logic [7:0] padrao_linha0,
  output logic [7:0] padrao_linha1,
  output logic [7:0] padrao_linha2,
  output logic [7:0] padrao_linha3,
  output logic [7:0] padrao_linha4,
  output logic [7:0] padrao_linha5,
  output logic [7:0] padrao_linha6,
  output logic [7:0] padrao_linha7
);

  localparam int LARG_CONT = $clog2(CICLOS_QUADRO);
  localparam logic [LARG_CONT-1:0] ULTIMO_CICLO = LARG_CONT'(CICLOS_QUADRO - 1);
  localparam idx_linha_t ULTIMA_LINHA = idx_linha_t'(NUM_LINHAS - 1);

  estado_t            estado_q, estado_d;
  logic [LARG_CONT-1:0] cont_q, cont_d;
  logic               sel_q, sel_d;
  logic               troca_latch_q, troca_latch_d;
  logic               feita_q, feita_d;
  idx_linha_t         lin_limpa_q, lin_limpa_d;
  linha_t             buf_q [2][NUM_LINHAS];
  linha_t             buf_d [2][NUM_LINHAS];
  linha_t             padrao_q [NUM_LINHAS];
  linha_t             padrao_d [NUM_LINHAS];
  logic               tras;
  logic               wrap;
  logic [1:0]         grant;

  assign tras = ~sel_q;
  assign wrap = (cont_q == ULTIMO_CICLO);

  arbitro_rr2 u_arbitro_rr2 (
    .clock    (clock),
    .reset    (reset),
    .habilita (estado_q == OCIOSO),
    .req      ({req_sob, req_jogo}),
    .grant    (grant)
  );

  assign ack_jogo = grant[0];
  assign ack_sob  = grant[1];

  // Free-running frame counter, independent of the FSM.
  assign cont_d = wrap ? '0 : cont_q + 1'b1;

  always_comb begin
    estado_d      = estado_q;
    troca_latch_d = troca_latch_q;
    lin_limpa_d   = lin_limpa_q;
    sel_d         = sel_q;
    feita_d       = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (limpar) begin
          estado_d    = LIMPEZA;
          lin_limpa_d = '0;
          if (troca_req) begin
            troca_latch_d = 1'b1;
          end
        end else if (troca_req) begin
          estado_d = AGUARDA_TROCA;
        end
      end
      LIMPEZA: begin
        if (troca_req) begin
          troca_latch_d = 1'b1;
        end
        lin_limpa_d = lin_limpa_q + 1'b1;
        if (lin_limpa_q == ULTIMA_LINHA) begin
          estado_d      = troca_latch_d ? AGUARDA_TROCA : OCIOSO;
          troca_latch_d = 1'b0;
        end
      end
      AGUARDA_TROCA: begin
        if (wrap) begin
          sel_d    = ~sel_q;
          estado_d = OCIOSO;
          feita_d  = 1'b1;
        end
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  // Only the back buffer is ever written; acks are already zero outside OCIOSO.
  always_comb begin
    buf_d = buf_q;
    if (estado_q == LIMPEZA) begin
      buf_d[tras][lin_limpa_q] = '0;
    end else if (ack_jogo) begin
      buf_d[tras][linha_jogo] = dado_jogo;
    end else if (ack_sob) begin
      buf_d[tras][linha_sob] = dado_sob;
    end
  end

  // Using sel_d lines the new picture up with the troca_feita pulse; the
  // incoming front buffer is never written on the swap edge.
  always_comb begin
    for (int r = 0; r < NUM_LINHAS; r++) begin
      padrao_d[r] = buf_q[sel_d][r];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q      <= OCIOSO;
      cont_q        <= '0;
      sel_q         <= 1'b0;
      troca_latch_q <= 1'b0;
      feita_q       <= 1'b0;
      lin_limpa_q   <= '0;
      buf_q         <= '{default: '0};
      padrao_q      <= '{default: '0};
    end else begin
      estado_q      <= estado_d;
      cont_q        <= cont_d;
      sel_q         <= sel_d;
      troca_latch_q <= troca_latch_d;
      feita_q       <= feita_d;
      lin_limpa_q   <= lin_limpa_d;
      buf_q         <= buf_d;
      padrao_q      <= padrao_d;
    end
  end

  assign troca_pendente = (estado_q == AGUARDA_TROCA) || troca_latch_q;
  assign troca_feita    = feita_q;

  assign padrao_linha0 = padrao_q[0];
  assign padrao_linha1 = padrao_q[1];
  assign padrao_linha2 = padrao_q[2];
  assign padrao_linha3 = padrao_q[3];
  assign padrao_linha4 = padrao_q[4];
  assign padrao_linha5 = padrao_q[5];
  assign padrao_linha6 = padrao_q[6];
  assign padrao_linha7 = padrao_q[7];

endmodule

// File: tb/tb_arbitro_quadro_matriz.sv
// tb/tb_arbitro_quadro_matriz.sv - directed self-checking bench for arbitro_quadro_matriz
module tb_arbitro_quadro_matriz;

  localparam int C   = 32;
  localparam int LIM = 3 * C;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       req_jogo = 1'b0, req_sob = 1'b0;
  logic [2:0] linha_jogo = '0, linha_sob = '0;
  logic [7:0] dado_jogo = '0, dado_sob = '0;
  logic       ack_jogo, ack_sob;
  logic       limpar = 1'b0, troca_req = 1'b0;
  logic       troca_pendente, troca_feita;
  logic [7:0] padrao [8];

  int comparadas = 0;
  int falhas     = 0;
  int m_cont;
  int n;
  int feitas;

  always #5 clock = ~clock;

  arbitro_quadro_matriz #(.CICLOS_QUADRO(C)) dut (
    .clock          (clock),
    .reset          (reset),
    .req_jogo       (req_jogo),
    .linha_jogo     (linha_jogo),
    .dado_jogo      (dado_jogo),
    .ack_jogo       (ack_jogo),
    .req_sob        (req_sob),
    .linha_sob      (linha_sob),
    .dado_sob       (dado_sob),
    .ack_sob        (ack_sob),
    .limpar         (limpar),
    .troca_req      (troca_req),
    .troca_pendente (troca_pendente),
    .troca_feita    (troca_feita),
    .padrao_linha0  (padrao[0]),
    .padrao_linha1  (padrao[1]),
    .padrao_linha2  (padrao[2]),
    .padrao_linha3  (padrao[3]),
    .padrao_linha4  (padrao[4]),
    .padrao_linha5  (padrao[5]),
    .padrao_linha6  (padrao[6]),
    .padrao_linha7  (padrao[7])
  );

  // Reference frame position: current counter value as seen between edges.
  always @(posedge clock or negedge reset) begin
    if (!reset) m_cont <= 0;
    else        m_cont <= (m_cont == C - 1) ? 0 : m_cont + 1;
  end

  task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    comparadas++;
    if (obs !== esp) begin
      falhas++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
    end
  endtask

  task automatic aplica_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic escreve(input bit quem, input logic [2:0] l, input logic [7:0] d);
    if (quem) begin req_sob = 1'b1; linha_sob = l; dado_sob = d; end
    else      begin req_jogo = 1'b1; linha_jogo = l; dado_jogo = d; end
    #1;
    confere(quem ? "ack_sob_escrita" : "ack_jogo_escrita", quem ? ack_sob : ack_jogo, 1'b1);
    @(negedge clock);
    req_sob = 1'b0;
    req_jogo = 1'b0;
  endtask

  // Counts cycles until troca_feita, checking troca_pendente stays high meanwhile.
  task automatic espera_feita(input int n0, output int n_out);
    int pend_baixo;
    pend_baixo = 0;
    n_out = n0;
    while (troca_feita !== 1'b1 && n_out < LIM) begin
      if (troca_pendente !== 1'b1) pend_baixo++;
      @(negedge clock);
      n_out++;
    end
    confere("troca_feita_chegou", troca_feita, 1'b1);
    confere("pendente_durante_espera", pend_baixo, 0);
    confere("pendente_apos_troca", troca_pendente, 1'b0);
  endtask

  task automatic dispara_troca(output int n_out);
    troca_req = 1'b1;
    @(negedge clock);
    troca_req = 1'b0;
    espera_feita(1, n_out);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    @(negedge clock);
    aplica_reset();

    // Reset state
    for (int r = 0; r < 8; r++) confere("reset_padrao", padrao[r], 8'h00);
    confere("reset_pendente", troca_pendente, 1'b0);
    confere("reset_feita", troca_feita, 1'b0);
    confere("reset_ack_jogo", ack_jogo, 1'b0);

    // Game writes a walking-one frame and swaps it in
    for (int r = 0; r < 8; r++) escreve(1'b0, 3'(r), 8'h01 << r);
    confere("front_intocado", padrao[0], 8'h00);
    troca_req = 1'b1;
    @(negedge clock);
    troca_req = 1'b0;
    confere("pendente_apos_req", troca_pendente, 1'b1);
    espera_feita(1, n);
    @(negedge clock);
    confere("feita_pulso_unico", troca_feita, 1'b0);
    for (int r = 0; r < 8; r++) confere("padrao_walking", padrao[r], 8'h01 << r);

    // Contended round-robin from reset: game first, then alternating
    aplica_reset();
    req_jogo = 1'b1; linha_jogo = 3'd0; dado_jogo = 8'h11;
    req_sob  = 1'b1; linha_sob  = 3'd1; dado_sob  = 8'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      confere("rr_ack_jogo", ack_jogo, (i % 2 == 0));
      confere("rr_ack_sob", ack_sob, (i % 2 == 1));
      confere("rr_nunca_ambos", ack_jogo & ack_sob, 1'b0);
      @(negedge clock);
    end
    req_jogo = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      confere("sob_sozinho", ack_sob, 1'b1);
      @(negedge clock);
    end
    req_sob = 1'b0;

    // Clear and swap in the same cycle
    aplica_reset();
    for (int r = 0; r < 8; r++) escreve(1'b1, 3'(r), 8'hFF);
    dispara_troca(n);
    @(negedge clock);
    for (int r = 0; r < 8; r++) confere("padrao_ff", padrao[r], 8'hFF);
    for (int r = 0; r < 8; r++) escreve(1'b1, 3'(r), 8'hFF);
    limpar = 1'b1; troca_req = 1'b1;
    @(negedge clock);
    limpar = 1'b0; troca_req = 1'b0;
    req_jogo = 1'b1; linha_jogo = 3'd5; dado_jogo = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      #1;
      confere("limpeza_ack_jogo", ack_jogo, 1'b0);
      confere("limpeza_pendente", troca_pendente, 1'b1);
      @(negedge clock);
    end
    req_jogo = 1'b0;
    espera_feita(0, n);
    @(negedge clock);
    for (int r = 0; r < 8; r++) confere("padrao_limpo", padrao[r], 8'h00);
    // Back buffer now holds the previous FF frame
    escreve(1'b0, 3'd3, 8'hA5);
    dispara_troca(n);
    @(negedge clock);
    for (int r = 0; r < 8; r++) confere("padrao_anterior", padrao[r], (r == 3) ? 8'hA5 : 8'hFF);

    // Swap latency relative to the frame wrap
    aplica_reset();
    n = 0;
    while (m_cont != C - 2 && n < LIM) begin @(negedge clock); n++; end
    confere("alcanca_c_menos_2", m_cont, C - 2);
    dispara_troca(n);
    confere("latencia_antes_wrap", n, 2);
    confere("cont_na_feita", m_cont, 0);
    dispara_troca(n);
    confere("latencia_apos_wrap", n, C);
    confere("cont_na_feita2", m_cont, 0);

    // Reset while waiting for the swap
    aplica_reset();
    escreve(1'b0, 3'd0, 8'h3C);
    dispara_troca(n);
    @(negedge clock);
    confere("padrao0_3c", padrao[0], 8'h3C);
    escreve(1'b0, 3'd0, 8'hC3);
    troca_req = 1'b1;
    @(negedge clock);
    troca_req = 1'b0;
    confere("aguarda_pendente", troca_pendente, 1'b1);
    #2 reset = 1'b0;
    #1;
    confere("reset_meio_padrao0", padrao[0], 8'h00);
    confere("reset_meio_pendente", troca_pendente, 1'b0);
    confere("reset_meio_feita", troca_feita, 1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    feitas = 0;
    for (int i = 0; i < C + 4; i++) begin
      if (troca_feita === 1'b1) feitas++;
      @(negedge clock);
    end
    confere("sem_feita_apos_reset", feitas, 0);
    confere("padrao0_segue_zero", padrao[0], 8'h00);
    req_jogo = 1'b1; req_sob = 1'b1;
    #1;
    confere("ack_jogo_retoma", ack_jogo, 1'b1);
    confere("ack_sob_perde", ack_sob, 1'b0);
    @(negedge clock);
    req_jogo = 1'b0; req_sob = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comparadas, falhas);
    $finish;
  end

endmodule
